// File: rtl/joystick_conditioner_pkg.sv
// Shared constants and helpers for the DB9 joystick conditioner.
// Kempston bit indices, debounce counter width, opposing-direction filter.
package joystick_conditioner_pkg;

   localparam int JOY_RIGHT = 0;
   localparam int JOY_LEFT  = 1;
   localparam int JOY_DOWN  = 2;
   localparam int JOY_UP    = 3;
   localparam int JOY_FIRE  = 4;
   localparam int JOY_BITS  = 5;
   localparam int DB_CNT_W  = 4;

   typedef logic [JOY_BITS-1:0] joy_vec_t;

   // Opposing directions cancel each other; fire passes through.
   function automatic joy_vec_t joy_filter(input joy_vec_t i_v);
      joy_vec_t w_f;
      w_f = i_v;
      if (i_v[JOY_UP] && i_v[JOY_DOWN]) begin
         w_f[JOY_UP]   = 1'b0;
         w_f[JOY_DOWN] = 1'b0;
      end
      if (i_v[JOY_LEFT] && i_v[JOY_RIGHT]) begin
         w_f[JOY_LEFT]  = 1'b0;
         w_f[JOY_RIGHT] = 1'b0;
      end
      return w_f;
   endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// One joystick pin: 2-flop synchroniser, active-high invert, tick debounce.
// Ports: i_clk, i_rst_n (sync, active-low), i_tick, i_pin_n (raw, low=pressed),
//        o_db (debounced, active-high).
module joy_debounce_bit
   import joystick_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_tick,
   input  logic i_pin_n,
   output logic o_db
);

   logic                r_sync1;
   logic                r_sync2;
   logic                r_db;
   logic [DB_CNT_W-1:0] r_cnt;
   logic                w_raw;

   assign w_raw = ~r_sync2;
   assign o_db  = r_db;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_db    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_pin_n;
         r_sync2 <= r_sync1;
         // Any agreeing cycle throws away partial progress.
         if (w_raw == r_db) begin
            r_cnt <= '0;
         end else if (i_tick) begin
            if (r_cnt == DB_CNT_W'(DEBOUNCE_TICKS - 1)) begin
               r_db  <= w_raw;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/joystick_conditioner.sv
// DB9 joystick conditioner: sync + debounce, opposing filter, autofire,
// registered Kempston byte. Ports: clk28, rst_n (sync, active-low),
// joyup/down/left/right/fire (raw, low=pressed), autofire_en,
// kempston[7:0] (active-high), joy_changed (1-cycle strobe on change).
module joystick_conditioner
   import joystick_conditioner_pkg::*;
#(
   parameter int TICK_DIV       = 28000,
   parameter int DEBOUNCE_TICKS = 4,
   parameter int AUTOFIRE_TICKS = 40
) (
   input  logic       clk28,
   input  logic       rst_n,
   input  logic       joyup,
   input  logic       joydown,
   input  logic       joyleft,
   input  logic       joyright,
   input  logic       joyfire,
   input  logic       autofire_en,
   output logic [7:0] kempston,
   output logic       joy_changed
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [DIV_W-1:0] r_div;
   logic             w_tick;
   joy_vec_t         w_pin_n;
   joy_vec_t         w_db;
   logic [7:0]       r_af_cnt;
   logic             r_af_ph;
   logic [7:0]       w_next;
   logic [7:0]       r_kempston;
   logic             r_changed;

   assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

   always_ff @(posedge clk28) begin
      if (!rst_n || w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign w_pin_n[JOY_RIGHT] = joyright;
   assign w_pin_n[JOY_LEFT]  = joyleft;
   assign w_pin_n[JOY_DOWN]  = joydown;
   assign w_pin_n[JOY_UP]    = joyup;
   assign w_pin_n[JOY_FIRE]  = joyfire;

   for (genvar gi = 0; gi < JOY_BITS; gi++) begin : g_db
      joy_debounce_bit #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
      ) u_db (
         .i_clk  (clk28),
         .i_rst_n(rst_n),
         .i_tick (w_tick),
         .i_pin_n(w_pin_n[gi]),
         .o_db   (w_db[gi])
      );
   end

   // Phase parks at 1 while idle so a fresh press fires at once.
   always_ff @(posedge clk28) begin
      if (!rst_n || !w_db[JOY_FIRE] || !autofire_en) begin
         r_af_cnt <= '0;
         r_af_ph  <= 1'b1;
      end else if (w_tick) begin
         if (r_af_cnt == 8'(AUTOFIRE_TICKS - 1)) begin
            r_af_cnt <= '0;
            r_af_ph  <= ~r_af_ph;
         end else begin
            r_af_cnt <= r_af_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_next = {3'b000, joy_filter(w_db)};
      w_next[JOY_FIRE] = w_db[JOY_FIRE] & (autofire_en ? r_af_ph : 1'b1);
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         r_kempston <= 8'h00;
         r_changed  <= 1'b0;
      end else begin
         r_kempston <= w_next;
         r_changed  <= (w_next != r_kempston);
      end
   end

   assign kempston    = r_kempston;
   assign joy_changed = r_changed;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Self-checking bench for joystick_conditioner with a small tick divider.
// Behavioural model compared every cycle plus directed literal checks.
module tb_joystick_conditioner;

   localparam int TD = 10;
   localparam int DT = 4;
   localparam int AT = 3;

   logic       clk28 = 1'b0;
   logic       rst_n;
   logic       joyup, joydown, joyleft, joyright, joyfire;
   logic       autofire_en;
   logic [7:0] kempston;
   logic       joy_changed;

   int n_cmp = 0;
   int n_err = 0;
   int n_pulse = 0;

   joystick_conditioner #(
      .TICK_DIV(TD),
      .DEBOUNCE_TICKS(DT),
      .AUTOFIRE_TICKS(AT)
   ) dut (
      .clk28(clk28),
      .rst_n(rst_n),
      .joyup(joyup),
      .joydown(joydown),
      .joyleft(joyleft),
      .joyright(joyright),
      .joyfire(joyfire),
      .autofire_en(autofire_en),
      .kempston(kempston),
      .joy_changed(joy_changed)
   );

   always #5 clk28 = ~clk28;

   // ---------------- behavioural model ----------------
   bit [4:0] s_a, s_b;
   bit [4:0] m_db;
   int       m_run [5];
   int       m_aft;
   int       rel;
   bit [7:0] m_kemp;
   bit       m_chg;
   bit       m_valid = 1'b0;

   always @(posedge clk28) begin
      bit [4:0] raw;
      bit       tk;
      bit [4:0] f;
      bit [7:0] nk;
      raw = ~s_b;
      tk  = (rel % TD) == TD - 1;
      f   = m_db;
      if (f[3] && f[2]) begin f[3] = 1'b0; f[2] = 1'b0; end
      if (f[1] && f[0]) begin f[1] = 1'b0; f[0] = 1'b0; end
      f[4] = m_db[4] && (!autofire_en || ((m_aft / AT) % 2 == 0));
      nk = {3'b000, f};
      if (!rst_n) begin
         m_db = '0;
         for (int b = 0; b < 5; b++) m_run[b] = 0;
         m_aft = 0; rel = 0;
         s_a = 5'h1F; s_b = 5'h1F;
         m_kemp = 8'h00; m_chg = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_chg  = (nk != m_kemp);
         m_kemp = nk;
         if (!(m_db[4] && autofire_en)) m_aft = 0;
         else if (tk) m_aft++;
         for (int b = 0; b < 5; b++) begin
            if (raw[b] == m_db[b]) m_run[b] = 0;
            else if (tk) begin
               m_run[b]++;
               if (m_run[b] == DT) begin
                  m_db[b] = raw[b];
                  m_run[b] = 0;
               end
            end
         end
         s_b = s_a;
         s_a = {joyfire, joyup, joydown, joyleft, joyright};
         rel++;
      end
   end

   always @(posedge clk28)
      if (m_valid && joy_changed) n_pulse++;

   always @(negedge clk28) begin
      if (m_valid) begin
         n_cmp++;
         if (kempston !== m_kemp || joy_changed !== m_chg) begin
            n_err++;
            $display("FAIL model t=%0t: kempston=%h chg=%b, required %h chg=%b",
                     $time, kempston, joy_changed, m_kemp, m_chg);
         end
      end
   end

   // ---------------- directed checks ----------------
   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk28);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  p0;
      bit  found;
      rst_n = 1'b0;
      autofire_en = 1'b0;
      {joyup, joydown, joyleft, joyright, joyfire} = 5'b00000;

      // 1: reset with every pin pressed
      settle(5);
      check("reset kempston", kempston, 8'h00);
      check("reset strobe", {7'd0, joy_changed}, 8'h00);
      rst_n = 1'b1;
      settle(40);
      check("t1 before 4th tick", kempston, 8'h00);
      settle(1);
      check("t1 after 4th tick", kempston, 8'h10);
      check("t1 strobe", {7'd0, joy_changed}, 8'h01);
      {joyup, joydown, joyleft, joyright, joyfire} = 5'b11111;
      settle(60);
      check("t1 release", kempston, 8'h00);

      // 2: clean press / release of right
      p0 = n_pulse;
      joyright = 1'b0;
      settle(60);
      check("t2 press", kempston, 8'h01);
      check("t2 press pulses", 8'(n_pulse - p0), 8'd1);
      p0 = n_pulse;
      joyright = 1'b1;
      settle(60);
      check("t2 release", kempston, 8'h00);
      check("t2 release pulses", 8'(n_pulse - p0), 8'd1);

      // 3: glitch of three ticks on up
      p0 = n_pulse;
      joyup = 1'b0;
      settle(30);
      joyup = 1'b1;
      settle(60);
      check("t3 glitch", kempston, 8'h00);
      check("t3 glitch pulses", 8'(n_pulse - p0), 8'd0);

      // 4: opposing left+right, then up
      p0 = n_pulse;
      joyleft = 1'b0;
      joyright = 1'b0;
      settle(60);
      check("t4 left+right", kempston, 8'h00);
      check("t4 lr pulses", 8'(n_pulse - p0), 8'd0);
      joyup = 1'b0;
      settle(60);
      check("t4 up", kempston, 8'h08);
      check("t4 up pulses", 8'(n_pulse - p0), 8'd1);
      p0 = n_pulse;
      {joyup, joyleft, joyright} = 3'b111;
      settle(60);
      check("t4 release", kempston, 8'h00);
      check("t4 release pulses", 8'(n_pulse - p0), 8'd1);

      // 5: autofire
      autofire_en = 1'b1;
      joyfire = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk28);
         if (kempston[4]) found = 1'b1;
      end
      check("t5 fire seen", {7'd0, found}, 8'h01);
      check("t5 first phase", kempston, 8'h10);
      check("t5 first strobe", {7'd0, joy_changed}, 8'h01);
      settle(15);
      check("t5 mid high", kempston, 8'h10);
      settle(30);
      check("t5 mid low", kempston, 8'h00);
      autofire_en = 1'b0;
      settle(1);
      check("t5 disable", kempston, 8'h10);
      check("t5 disable strobe", {7'd0, joy_changed}, 8'h01);
      joyfire = 1'b1;
      settle(60);
      check("t5 release", kempston, 8'h00);

      // 6: reset in the middle of a debounce
      rst_n = 1'b0;
      settle(1);
      rst_n = 1'b1;
      joydown = 1'b0;
      settle(25);
      check("t6 partial", kempston, 8'h00);
      rst_n = 1'b0;
      settle(1);
      rst_n = 1'b1;
      settle(40);
      check("t6 before restart done", kempston, 8'h00);
      settle(1);
      check("t6 down", kempston, 8'h04);
      check("t6 strobe", {7'd0, joy_changed}, 8'h01);
      joydown = 1'b1;
      settle(60);
      check("t6 release", kempston, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
